// File: rtl/serial_mem_loader_pkg.sv
// rtl/serial_mem_loader_pkg.sv - shared types and constants for the serial memory loader
package serial_mem_loader_pkg;

  localparam int unsigned ADDR_W_DEF    = 15;
  localparam logic [7:0]  SYNC_BYTE_DEF = 8'hA5;

  // Byte positions inside the four-byte header following SYNC
  localparam logic [1:0] OFF_ADDR_LO = 2'd0;
  localparam logic [1:0] OFF_ADDR_HI = 2'd1;
  localparam logic [1:0] OFF_CNT_LO  = 2'd2;
  localparam logic [1:0] OFF_CNT_HI  = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_HDR,
    ST_DATA,
    ST_CSUM
  } state_t;

  function automatic int unsigned timer_width(input int unsigned cycles);
    return (cycles < 2) ? 1 : $clog2(cycles + 1);
  endfunction

endpackage

// File: rtl/serial_mem_loader_timeout.sv
// rtl/serial_mem_loader_timeout.sv - loadable down-counter flagging inter-byte idle expiry
module serial_mem_loader_timeout #(
  parameter int unsigned LOAD_VALUE = 1000000,
  parameter int unsigned WIDTH      = 20
) (
  input  logic clk,
  input  logic reset_n,
  input  logic load,
  input  logic en,
  output logic expire
);

  logic [WIDTH-1:0] count;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (load) begin
      count <= WIDTH'(LOAD_VALUE);
    end else if (en && (count != '0)) begin
      count <= count - WIDTH'(1);
    end
  end

  // Fires on the last counting cycle so the owner leaves the frame exactly LOAD_VALUE cycles after the load
  assign expire = en && !load && (count == WIDTH'(1));

endmodule

// File: rtl/serial_mem_loader.sv
// rtl/serial_mem_loader.sv - parses framed UART load packets and writes 32-bit words to memory port 2
module serial_mem_loader
  import serial_mem_loader_pkg::*;
#(
  parameter int unsigned ADDR_W         = ADDR_W_DEF,
  parameter int unsigned TIMEOUT_CYCLES = 1000000,
  parameter logic [7:0]  SYNC_BYTE      = SYNC_BYTE_DEF
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  output logic [ADDR_W-1:0] mem_address,
  output logic [31:0]       mem_writedata,
  output logic [3:0]        mem_byteenable,
  output logic              mem_chipselect,
  output logic              mem_write,
  output logic              mem_clken,
  output logic              busy,
  output logic              done,
  output logic              err_csum,
  output logic              err_timeout,
  output logic [15:0]       words_written
);

  localparam int unsigned TMR_W = timer_width(TIMEOUT_CYCLES);

  state_t            state, next_state;
  logic [1:0]        byte_idx;
  logic [ADDR_W-1:0] start_addr;
  logic [15:0]       word_count;
  logic [7:0]        csum;
  logic [31:0]       word_sr;
  logic              expire;

  logic start_frame, fire_write, fire_done, fire_csum, fire_to;

  assign rx_ready       = 1'b1;
  assign mem_byteenable = 4'hF;
  assign mem_clken      = 1'b1;
  assign mem_chipselect = mem_write;
  assign busy           = (state != ST_IDLE);

  serial_mem_loader_timeout #(
    .LOAD_VALUE (TIMEOUT_CYCLES),
    .WIDTH      (TMR_W)
  ) u_timeout (
    .clk     (clk),
    .reset_n (reset_n),
    .load    (rx_valid),
    .en      ((TIMEOUT_CYCLES != 0) && (state != ST_IDLE)),
    .expire  (expire)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= ST_IDLE;
    else          state <= next_state;
  end

  always_comb begin
    next_state  = state;
    start_frame = 1'b0;
    fire_write  = 1'b0;
    fire_done   = 1'b0;
    fire_csum   = 1'b0;
    fire_to     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (rx_valid && (rx_data == SYNC_BYTE)) begin
          next_state  = ST_HDR;
          start_frame = 1'b1;
        end
      end
      ST_HDR: begin
        if (expire) begin
          next_state = ST_IDLE;
          fire_to    = 1'b1;
        end else if (rx_valid && (byte_idx == OFF_CNT_HI)) begin
          next_state = ({rx_data, word_count[7:0]} != 16'd0) ? ST_DATA : ST_CSUM;
        end
      end
      ST_DATA: begin
        if (expire) begin
          next_state = ST_IDLE;
          fire_to    = 1'b1;
        end else if (rx_valid && (byte_idx == 2'd3)) begin
          fire_write = 1'b1;
          if ((words_written + 16'd1) == word_count) next_state = ST_CSUM;
        end
      end
      ST_CSUM: begin
        if (expire) begin
          next_state = ST_IDLE;
          fire_to    = 1'b1;
        end else if (rx_valid) begin
          next_state = ST_IDLE;
          if (rx_data == csum) fire_done = 1'b1;
          else                 fire_csum = 1'b1;
        end
      end
      default: next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      byte_idx      <= '0;
      start_addr    <= '0;
      word_count    <= '0;
      csum          <= '0;
      word_sr       <= '0;
      mem_address   <= '0;
      mem_writedata <= '0;
      mem_write     <= 1'b0;
      words_written <= '0;
      done          <= 1'b0;
      err_csum      <= 1'b0;
      err_timeout   <= 1'b0;
    end else begin
      mem_write   <= fire_write;
      done        <= fire_done;
      err_csum    <= fire_csum;
      err_timeout <= fire_to;

      if (start_frame) begin
        byte_idx      <= '0;
        csum          <= '0;
        words_written <= '0;
      end else if (rx_valid && ((state == ST_HDR) || (state == ST_DATA))) begin
        byte_idx <= byte_idx + 2'd1;
        csum     <= csum ^ rx_data;
      end

      if (rx_valid && (state == ST_HDR)) begin
        case (byte_idx)
          OFF_ADDR_LO: start_addr[7:0]        <= rx_data;
          OFF_ADDR_HI: start_addr[ADDR_W-1:8] <= rx_data[ADDR_W-9:0];
          OFF_CNT_LO:  word_count[7:0]        <= rx_data;
          default:     word_count[15:8]       <= rx_data;
        endcase
      end

      // Little-endian packing: each new byte enters at the top and the word slides down
      if (rx_valid && (state == ST_DATA)) word_sr <= {rx_data, word_sr[31:8]};

      if (fire_write) begin
        mem_writedata <= {rx_data, word_sr[31:8]};
        mem_address   <= start_addr + words_written[ADDR_W-1:0];
        words_written <= words_written + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_serial_mem_loader.sv
// tb/tb_serial_mem_loader.sv - randomized self-checking bench for serial_mem_loader
module tb_serial_mem_loader;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic [14:0] mem_address;
  logic [31:0] mem_writedata;
  logic [3:0]  mem_byteenable;
  logic        mem_chipselect;
  logic        mem_write;
  logic        mem_clken;
  logic        busy;
  logic        done;
  logic        err_csum;
  logic        err_timeout;
  logic [15:0] words_written;

  int checks = 0;
  int failures = 0;

  logic [7:0]  tx_q[$];
  logic [46:0] exp_q[$];
  logic [46:0] act_q[$];
  int done_cnt, csum_cnt, to_cnt, strobe_bad;
  int exp_n;

  always #5 clk = ~clk;

  serial_mem_loader #(
    .ADDR_W         (15),
    .TIMEOUT_CYCLES (50),
    .SYNC_BYTE      (8'hA5)
  ) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .rx_data        (rx_data),
    .rx_valid       (rx_valid),
    .rx_ready       (rx_ready),
    .mem_address    (mem_address),
    .mem_writedata  (mem_writedata),
    .mem_byteenable (mem_byteenable),
    .mem_chipselect (mem_chipselect),
    .mem_write      (mem_write),
    .mem_clken      (mem_clken),
    .busy           (busy),
    .done           (done),
    .err_csum       (err_csum),
    .err_timeout    (err_timeout),
    .words_written  (words_written)
  );

  always @(negedge clk) begin
    if (mem_write) begin
      act_q.push_back({mem_address, mem_writedata});
      if (!mem_chipselect || mem_byteenable !== 4'hF) strobe_bad++;
    end
    if (done)        done_cnt++;
    if (err_csum)    csum_cnt++;
    if (err_timeout) to_cnt++;
  end

  task automatic clear_obs();
    act_q.delete();
    done_cnt = 0;
    csum_cnt = 0;
    to_cnt = 0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
  endtask

  task automatic send_frame(input int gap_max);
    foreach (tx_q[k]) begin
      send_byte(tx_q[k]);
      if (gap_max > 0) idle($urandom_range(gap_max, 0));
    end
  endtask

  // Reference model: builds the byte stream and the writes the memory should see
  task automatic build_frame(input logic [15:0] addr, input int n, input bit bad);
    logic [7:0]  cs;
    logic [31:0] w;
    int          a;
    tx_q.delete();
    exp_q.delete();
    exp_n = n;
    tx_q.push_back(8'hA5);
    tx_q.push_back(addr[7:0]);
    tx_q.push_back(addr[15:8]);
    tx_q.push_back(8'(n));
    tx_q.push_back(8'(n >> 8));
    for (int i = 0; i < n; i++) begin
      w = $urandom;
      for (int b = 0; b < 4; b++) tx_q.push_back(8'(w >> (8 * b)));
      a = (int'(addr) % 32768 + i) % 32768;
      exp_q.push_back({15'(a), w});
    end
    cs = 8'h00;
    for (int k = 1; k < tx_q.size(); k++) cs = cs ^ tx_q[k];
    if (bad) cs = cs ^ 8'(1 << $urandom_range(7, 0));
    tx_q.push_back(cs);
  endtask

  task automatic test_reset();
    reset_n  = 1'b0;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    idle(3);
    checks++;
    if ({mem_write, mem_chipselect, done, err_csum, err_timeout, busy} !== 6'b0) begin
      failures++;
      $display("FAIL reset_strobes actual=%b required=000000",
               {mem_write, mem_chipselect, done, err_csum, err_timeout, busy});
    end
    checks++;
    if ({mem_address, mem_writedata, words_written} !== 63'd0) begin
      failures++;
      $display("FAIL reset_regs actual addr=%h data=%h ww=%0d required 0", mem_address, mem_writedata,
               words_written);
    end
    checks++;
    if ({rx_ready, mem_byteenable, mem_clken} !== 6'b1_1111_1) begin
      failures++;
      $display("FAIL reset_consts actual=%b required=111111", {rx_ready, mem_byteenable, mem_clken});
    end
    reset_n = 1'b1;
    idle(2);
  endtask

  task automatic test_good_frame();
    logic [7:0] f[10] = '{8'hA5, 8'h10, 8'h00, 8'h01, 8'h00, 8'h44, 8'h33, 8'h22, 8'h11, 8'h55};
    clear_obs();
    for (int i = 0; i < 10; i++) send_byte(f[i]);
    idle(3);
    checks++;
    if (act_q.size() != 1 || act_q[0] !== {15'h0010, 32'h11223344}) begin
      failures++;
      $display("FAIL good_write actual n=%0d w=%h required n=1 w=%h", act_q.size(),
               (act_q.size() > 0) ? act_q[0] : 47'd0, {15'h0010, 32'h11223344});
    end
    checks++;
    if ({done_cnt, csum_cnt, to_cnt} !== {32'd1, 32'd0, 32'd0} || words_written !== 16'd1) begin
      failures++;
      $display("FAIL good_status actual done=%0d csum=%0d to=%0d ww=%0d required 1 0 0 1",
               done_cnt, csum_cnt, to_cnt, words_written);
    end
  endtask

  task automatic test_bad_csum();
    logic [7:0] f[10] = '{8'hA5, 8'h10, 8'h00, 8'h01, 8'h00, 8'h44, 8'h33, 8'h22, 8'h11, 8'h54};
    clear_obs();
    for (int i = 0; i < 10; i++) send_byte(f[i]);
    idle(3);
    checks++;
    if (act_q.size() != 1 || act_q[0] !== {15'h0010, 32'h11223344}) begin
      failures++;
      $display("FAIL badcs_write actual n=%0d required n=1 at 0010", act_q.size());
    end
    checks++;
    if (done_cnt != 0 || csum_cnt != 1 || busy !== 1'b0) begin
      failures++;
      $display("FAIL badcs_status actual done=%0d csum=%0d busy=%b required 0 1 0", done_cnt, csum_cnt, busy);
    end
  endtask

  task automatic test_zero_count();
    logic [7:0] f[6] = '{8'hA5, 8'h20, 8'h00, 8'h00, 8'h00, 8'h20};
    clear_obs();
    for (int i = 0; i < 6; i++) send_byte(f[i]);
    idle(3);
    checks++;
    if (act_q.size() != 0 || done_cnt != 1 || csum_cnt != 0) begin
      failures++;
      $display("FAIL zero_count actual writes=%0d done=%0d csum=%0d required 0 1 0",
               act_q.size(), done_cnt, csum_cnt);
    end
  endtask

  task automatic test_frames(input string name, input int nframes, input bit wrap);
    bit bad;
    for (int f = 0; f < nframes; f++) begin
      bad = wrap ? 1'b0 : ($urandom_range(3, 0) == 0);
      if (wrap) build_frame(16'h7FFF, 2, 1'b0);
      else      build_frame(16'($urandom), $urandom_range(5, 1), bad);
      clear_obs();
      send_frame(wrap ? 0 : 5);
      idle(3);
      checks++;
      if (act_q.size() != exp_q.size()) begin
        failures++;
        $display("FAIL %s_nwrites frame %0d actual=%0d required=%0d", name, f, act_q.size(), exp_q.size());
      end else begin
        foreach (exp_q[i]) begin
          checks++;
          if (act_q[i] !== exp_q[i]) begin
            failures++;
            $display("FAIL %s_write frame %0d idx %0d actual=%h required=%h", name, f, i, act_q[i], exp_q[i]);
          end
        end
      end
      checks++;
      if (done_cnt != int'(!bad) || csum_cnt != int'(bad) || words_written !== 16'(exp_n)) begin
        failures++;
        $display("FAIL %s_status frame %0d actual done=%0d csum=%0d ww=%0d required %0d %0d %0d",
                 name, f, done_cnt, csum_cnt, words_written, !bad, bad, exp_n);
      end
    end
  endtask

  task automatic test_timeout();
    int seen;
    build_frame(16'h0123, 1, 1'b0);
    clear_obs();
    for (int k = 0; k < 7; k++) send_byte(tx_q[k]);
    seen = 0;
    for (int i = 1; i <= 60; i++) begin
      @(posedge clk);
      #1;
      if (err_timeout) begin
        seen = i;
        break;
      end
    end
    checks++;
    if (seen != 50) begin
      failures++;
      $display("FAIL timeout_cycle actual=%0d required=50", seen);
    end
    idle(2);
    checks++;
    if (act_q.size() != 0 || busy !== 1'b0 || to_cnt != 1 || done_cnt != 0) begin
      failures++;
      $display("FAIL timeout_status actual writes=%0d busy=%b to=%0d done=%0d required 0 0 1 0",
               act_q.size(), busy, to_cnt, done_cnt);
    end
    test_frames("after_to", 1, 1'b0);
  endtask

  task automatic test_back_to_back();
    build_frame(16'h0100, 4, 1'b0);
    clear_obs();
    for (int k = 0; k < 13; k++) send_byte(tx_q[k]);
    reset_n = 1'b0;
    #1;
    checks++;
    if ({mem_write, mem_chipselect, done, err_csum, err_timeout, busy} !== 6'b0 ||
        {mem_address, mem_writedata, words_written} !== 63'd0 ||
        {rx_ready, mem_byteenable, mem_clken} !== 6'b1_1111_1) begin
      failures++;
      $display("FAIL b2b_reset_outputs actual we=%b busy=%b addr=%h data=%h ww=%0d required reset values",
               mem_write, busy, mem_address, mem_writedata, words_written);
    end
    idle(3);
    reset_n = 1'b1;
    idle(2);
    checks++;
    if (act_q.size() != 1 || act_q[0] !== exp_q[0]) begin
      failures++;
      $display("FAIL b2b_writes actual n=%0d required n=1 w=%h", act_q.size(), exp_q[0]);
    end
    send_byte(8'h00);
    test_frames("post_reset", 1, 1'b0);
    checks++;
    if (strobe_bad != 0) begin
      failures++;
      $display("FAIL write_strobes actual bad=%0d required=0", strobe_bad);
    end
  endtask

  initial begin
    strobe_bad = 0;
    clear_obs();
    test_reset();
    test_good_frame();
    test_frames("wrap", 1, 1'b1);
    test_bad_csum();
    test_zero_count();
    test_frames("random", 8, 1'b0);
    test_timeout();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
